// File: rtl/snes_pkg.sv
//------------------------------------------------------------------------------
// snes_pkg
// Shared constants for the SNES button event path: button bit indices,
// event word layout and the default set of event-generating buttons.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package snes_pkg;

  // Bit positions of the buttons in the 16-bit controller word.
  localparam int BTN_B     = 0;
  localparam int BTN_Y     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_A     = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;

  // Event word: {press, code[3:0]}.
  localparam int EV_W      = 5;
  localparam int PRESS_BIT = 4;
  localparam int CODE_MSB  = 3;

  // Every real button generates events; the ID nibble does not.
  localparam logic [15:0] DEFAULT_BUTTON_MASK = 16'(
      (1 << BTN_B)    | (1 << BTN_Y)    | (1 << BTN_SEL)   | (1 << BTN_START) |
      (1 << BTN_UP)   | (1 << BTN_DOWN) | (1 << BTN_LEFT)  | (1 << BTN_RIGHT) |
      (1 << BTN_A)    | (1 << BTN_X)    | (1 << BTN_L)     | (1 << BTN_R));

  // Scanner states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Pack a press/release flag and a bit index into an event word.
  function automatic logic [EV_W-1:0] make_event(input logic press, input logic [3:0] code);
    logic [EV_W-1:0] ev;
    ev                = '0;
    ev[PRESS_BIT]     = press;
    ev[CODE_MSB:0]    = code;
    return ev;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snes_event_fifo.sv
//------------------------------------------------------------------------------
// snes_event_fifo
// Synchronous show-ahead FIFO. A push into a full FIFO is dropped even when a
// pop happens in the same cycle; the head entry is always visible on head_o.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module snes_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage, pointers (power-of-two wrap) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/snes_button_events.sv
//------------------------------------------------------------------------------
// snes_button_events
// Turns SNES button samples into press/release events. A scanner walks the
// mismatch between the latest sample (cur) and the committed state (ref),
// one bit per cycle, pushing an event and committing that bit each time.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module snes_button_events
  import snes_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] BUTTON_MASK = DEFAULT_BUTTON_MASK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid_i,
  input  logic [15:0]                   buttons_i,
  output logic                          ev_valid_o,
  input  logic                          ev_ready_i,
  output logic [EV_W-1:0]               ev_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count_o,
  output logic [15:0]                   state_o,
  output logic                          drop_o,
  input  logic                          drop_clr_i
);

  scan_state_e     st_q, st_d;
  logic [15:0]     cur_q, cur_d;
  logic [15:0]     ref_q, ref_d;
  logic [3:0]      idx_q, idx_d;
  logic            drop_q, drop_d;

  logic [15:0]     masked_sample;
  logic [15:0]     diff;
  logic            scan_active;
  logic            bit_diff;
  logic            push;
  logic [EV_W-1:0] push_data;
  logic            drop_set;
  logic            fifo_full;
  logic            fifo_empty;

  assign masked_sample = buttons_i & BUTTON_MASK;
  assign diff          = cur_q ^ ref_q;
  // IDLE keeps idx at 0, so a fresh mismatch is serviced from bit 0 in the
  // very cycle it becomes visible rather than one cycle later.
  assign scan_active   = (st_q == ST_SCAN) || (diff != '0);
  assign bit_diff      = diff[idx_q];

  // New samples are taken in any scanner state.
  always_comb begin
    cur_d = cur_q;
    if (sample_valid_i) begin
      cur_d = masked_sample;
    end
  end

  // Scanner: visit one bit per cycle, emit and commit mismatches, stall on full.
  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    ref_d     = ref_q;
    push      = 1'b0;
    push_data = make_event(cur_q[idx_q], idx_q);
    if (scan_active) begin
      if (!bit_diff) begin
        idx_d = idx_q + 4'd1;
      end else if (!fifo_full) begin
        push         = 1'b1;
        ref_d[idx_q] = cur_q[idx_q];
        idx_d        = idx_q + 4'd1;
      end
      if ((cur_q ^ ref_d) == '0) begin
        st_d  = ST_IDLE;
        idx_d = '0;
      end else begin
        st_d  = ST_SCAN;
      end
    end
  end

  // A bit already pending that the new sample returns to its committed value
  // is a press+release pair that will never be reported.
  assign drop_set = sample_valid_i && ((diff & ~(masked_sample ^ ref_q) & BUTTON_MASK) != '0);

  // Sticky drop flag; a new drop wins over a clear in the same cycle.
  always_comb begin
    drop_d = drop_q;
    if (drop_clr_i) begin
      drop_d = 1'b0;
    end
    if (drop_set) begin
      drop_d = 1'b1;
    end
  end

  // Scanner, sample and drop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cur_q  <= '0;
      ref_q  <= '0;
      idx_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cur_q  <= cur_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      drop_q <= drop_d;
    end
  end

  snes_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (ev_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (ev_count_o),
    .head_o  (ev_data_o)
  );

  assign ev_valid_o = !fifo_empty;
  assign state_o    = ref_q;
  assign drop_o     = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_snes_button_events.sv
//------------------------------------------------------------------------------
// tb_snes_button_events
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized phase checked against an event-list model of the button word.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_snes_button_events;
  import snes_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [15:0] MASK  = 16'h0FFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [15:0]   buttons = '0;
  logic          ev_ready = 1'b0;
  logic          drop_clr = 1'b0;
  logic          ev_valid;
  logic [4:0]    ev_data;
  logic [CW-1:0] ev_count;
  logic [15:0]   state;
  logic          drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: never ready, 1: always ready, 2: random
  logic [4:0] got_q[$];
  int         got_cyc[$];

  typedef struct {
    logic [15:0] btn;
    int          nev;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [15:0] st;
  } vec_t;
  vec_t vecs[9];

  snes_button_events #(
    .FIFO_DEPTH  (DEPTH),
    .BUTTON_MASK (MASK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid_i (sample_valid),
    .buttons_i      (buttons),
    .ev_valid_o     (ev_valid),
    .ev_ready_i     (ev_ready),
    .ev_data_o      (ev_data),
    .ev_count_o     (ev_count),
    .state_o        (state),
    .drop_o         (drop),
    .drop_clr_i     (drop_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, record a handshake.
  task automatic step(input logic sv, input logic [15:0] b, input logic clr);
    @(negedge clk);
    sample_valid = sv;
    buttons      = b;
    drop_clr     = clr;
    case (ready_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      default: ev_ready = ($urandom_range(3) != 0);
    endcase
    if (ev_valid && ev_ready) begin
      got_q.push_back(ev_data);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sample_valid = 1'b0; buttons = '0; drop_clr = 1'b0;
    ev_ready = 1'b0; ready_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    int          n;
    int          bad;
    logic [15:0] view;
    logic [15:0] prev;
    logic [15:0] last;
    logic [15:0] b;
    logic [15:0] dmask;
    logic        sv;
    logic        ovf;
    logic [4:0]  exp_q[$];
    int          exp_off[4];
    logic [4:0]  exp_ev[4];

    vecs[0] = '{16'h0001, 1,  5'h10, 5'h10, 16'h0001};
    vecs[1] = '{16'h0000, 1,  5'h00, 5'h00, 16'h0000};
    vecs[2] = '{16'h0911, 4,  5'h10, 5'h1B, 16'h0911};
    vecs[3] = '{16'hF911, 0,  5'h1F, 5'h1F, 16'h0911};
    vecs[4] = '{16'h0810, 2,  5'h00, 5'h08, 16'h0810};
    vecs[5] = '{16'h0FFF, 10, 5'h10, 5'h1A, 16'h0FFF};
    vecs[6] = '{16'hFFFF, 0,  5'h1F, 5'h1F, 16'h0FFF};
    vecs[7] = '{16'h0800, 11, 5'h00, 5'h0A, 16'h0800};
    vecs[8] = '{16'h8000, 1,  5'h0B, 5'h0B, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ev_valid", 32'(ev_valid), 0);
    check("rst_ev_count", 32'(ev_count), 0);
    check("rst_ev_data",  32'(ev_data), 0);
    check("rst_state",    32'(state), 0);
    check("rst_drop",     32'(drop), 0);
    rst_n = 1'b1;

    // Latency and ordering of a multi-bit press
    exp_off = '{2, 6, 10, 13};
    exp_ev  = '{5'h10, 5'h14, 5'h18, 5'h1B};
    ready_mode = 1;
    idle(2);
    got_q.delete(); got_cyc.delete();
    step(1'b1, 16'h0911, 1'b0);
    n = cyc;
    idle(18);
    check("lat_nevents", 32'(got_q.size()), 4);
    while (got_q.size() < 4) begin
      got_q.push_back(5'h1F);
      got_cyc.push_back(-1);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat_cycle%0d", i), 32'(got_cyc[i] - n), 32'(exp_off[i]));
      check($sformatf("lat_event%0d", i), 32'(got_q[i]), 32'(exp_ev[i]));
    end

    // Table-driven single samples, consumer always ready
    do_reset();
    ready_mode = 1;
    for (int v = 0; v < 9; v++) begin
      got_q.delete();
      step(1'b1, vecs[v].btn, 1'b0);
      idle(24);
      check($sformatf("vec%0d_nev", v), 32'(got_q.size()), 32'(vecs[v].nev));
      if (vecs[v].nev > 0 && got_q.size() > 0) begin
        check($sformatf("vec%0d_first", v), 32'(got_q[0]), 32'(vecs[v].first));
        check($sformatf("vec%0d_last", v), 32'(got_q[got_q.size()-1]), 32'(vecs[v].last));
      end
      check($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].st));
      check($sformatf("vec%0d_drop", v), 32'(drop), 0);
    end

    // Back-pressure: FIFO fills, scanner stalls, nothing lost
    do_reset();
    step(1'b1, 16'h0FFF, 1'b0);
    idle(20);
    check("bp_count_full", 32'(ev_count), 32'(DEPTH));
    check("bp_state_stall", 32'(state), 32'h00FF);
    check("bp_valid", 32'(ev_valid), 1);
    check("bp_no_pop", 32'(got_q.size()), 0);
    ready_mode = 1;
    idle(30);
    check("bp_total", 32'(got_q.size()), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      check($sformatf("bp_ev%0d", i), 32'(got_q[i]), 32'({1'b1, 4'(i)}));
    end
    check("bp_state", 32'(state), 32'h0FFF);
    check("bp_drop", 32'(drop), 0);
    check("bp_count_empty", 32'(ev_count), 0);

    // Drop with drop_clr overlapping the drop condition
    do_reset();
    step(1'b1, 16'h0FFF, 1'b0);
    idle(20);
    step(1'b1, 16'h0000, 1'b1);
    idle(1);
    check("drop_set_wins", 32'(drop), 1);
    ready_mode = 1;
    idle(40);
    view = '0; bad = 0;
    foreach (got_q[i]) begin
      if (view[got_q[i][3:0]] == got_q[i][4]) bad++;
      view[got_q[i][3:0]] = got_q[i][4];
    end
    check("drop_ev_total", 32'(got_q.size()), 16);
    check("drop_toggle_ok", 32'(bad), 0);
    check("drop_state_view", 32'(state), 32'(view));
    check("drop_state_zero", 32'(state), 0);
    check("drop_sticky", 32'(drop), 1);
    step(1'b0, 16'h0000, 1'b1);
    idle(1);
    check("drop_cleared", 32'(drop), 0);

    // Asynchronous reset in the middle of a scan
    do_reset();
    step(1'b1, 16'h0FFF, 1'b0);
    idle(4);
    step(1'b1, 16'h0000, 1'b0);
    idle(2);
    check("mid_pre_drop", 32'(drop), 1);
    check("mid_pre_count", 32'(ev_count != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ev_valid), 0);
    check("mid_rst_count", 32'(ev_count), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_drop", 32'(drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    ready_mode = 1;
    idle(20);
    check("mid_no_events", 32'(got_q.size()), 0);

    // Random, well-separated samples: exact ascending event lists
    do_reset();
    prev = '0;
    for (int it = 0; it < 40; it++) begin
      b = 16'($urandom);
      dmask = (b & MASK) ^ prev;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
        if (dmask[i]) exp_q.push_back({b[i], 4'(i)});
      end
      got_q.delete();
      ready_mode = 2;
      step(1'b1, b, 1'b0);
      n = 0;
      while (got_q.size() < exp_q.size() && n < 300) begin
        step(1'b0, 16'h0000, 1'b0);
        n++;
      end
      idle(3);
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        if (got_q[i] !== exp_q[i]) bad++;
      end
      check($sformatf("rnd%0d_events", it), 32'(bad), 0);
      check($sformatf("rnd%0d_state", it), 32'(state), 32'(b & MASK));
      check($sformatf("rnd%0d_drop", it), 32'(drop), 0);
      prev = b & MASK;
    end

    // Random dense samples with random back-pressure
    got_q.delete();
    view = prev; last = prev; ovf = 1'b0;
    ready_mode = 2;
    for (int c = 0; c < 400; c++) begin
      sv = ($urandom_range(4) == 0);
      b  = 16'($urandom);
      if (sv) last = b & MASK;
      step(sv, b, 1'b0);
      if (ev_count > CW'(DEPTH)) ovf = 1'b1;
    end
    ready_mode = 1;
    idle(40);
    bad = 0;
    foreach (got_q[i]) begin
      if (view[got_q[i][3:0]] == got_q[i][4]) bad++;
      if ((MASK[got_q[i][3:0]]) == 1'b0) bad++;
      view[got_q[i][3:0]] = got_q[i][4];
    end
    check("dense_toggle_ok", 32'(bad), 0);
    check("dense_state_view", 32'(state), 32'(view));
    check("dense_drained", 32'(ev_count), 0);
    check("dense_no_overflow", 32'(ovf), 0);
    if (!drop) begin
      check("dense_state_last", 32'(view), 32'(last));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
